// File: rtl/eth_axis_packet_gen.sv
// eth_axis_packet_gen
//   AXI-Stream test-packet generator for the eth_10g TX port. Emits packets of
//   packet_len bytes with a partial tkeep on the last beat. Packets are separated
//   by gap_cycles idle cycles. A run stops after num_packets packets (0 = unlimited).
//   The payload is either a counter or PRBS31. Running packet and byte totals are kept.
// Ports
//   clk, reset             single clock, synchronous active-high reset
//   enable                 run request (level)
//   mode                   0 = {pattern[DW-1:32], seq, beat_idx}, 1 = PRBS31
//   packet_len, gap_cycles packet size in bytes, idle cycles between packets
//   num_packets            packets per run, 0 = unlimited
//   pattern                upper payload (mode 0) / PRBS seed in [30:0] (mode 1)
//   m00_axis_*             AXI-Stream master
//   busy, done             not idle / packet limit reached
//   pkt_count, byte_count  packets and bytes sent since reset (wrap)
module eth_axis_packet_gen #(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    mode,
  input  logic [LEN_WIDTH-1:0]    packet_len,
  input  logic [LEN_WIDTH-1:0]    gap_cycles,
  input  logic [CNT_WIDTH-1:0]    num_packets,
  input  logic [DATA_WIDTH-1:0]   pattern,
  output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m00_axis_tkeep,
  output logic                    m00_axis_tvalid,
  input  logic                    m00_axis_tready,
  output logic                    m00_axis_tlast,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_WIDTH-1:0]    pkt_count,
  output logic [CNT_WIDTH+15:0]   byte_count
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int KW    = $clog2(BYTES + 1);
  localparam logic [LEN_WIDTH-1:0] BYTES_L = LEN_WIDTH'(BYTES);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
  state_t state, state_d;

  // latched run configuration
  logic [LEN_WIDTH-1:0]  gap_q;
  logic                  mode_q;
  logic [DATA_WIDTH-1:0] pat_q;
  logic [CNT_WIDTH-1:0]  num_q, run_q, run_d;
  // per-packet progress; left_q = bytes still to send including the beat on the bus
  logic [LEN_WIDTH-1:0]  left_q, left_d, gap_cnt_q, gap_cnt_d;
  logic [15:0]           beat_idx_q, beat_idx_d, seq_q, seq_d;
  logic [30:0]           lfsr_q, lfsr_d;
  // next values of the registered outputs
  logic [DATA_WIDTH-1:0] tdata_d;
  logic [BYTES-1:0]      tkeep_d;
  logic                  tlast_d;
  logic [CNT_WIDTH-1:0]  pkt_d;
  logic [CNT_WIDTH+15:0] bcnt_d;

  // beat builder inputs/outputs
  logic                  hs, can_start, start, adv, b_mode, nb;
  logic [DATA_WIDTH-1:0] b_pat, prbs;
  logic [15:0]           b_idx;
  logic [LEN_WIDTH-1:0]  b_left;
  logic [30:0]           b_lfsr, s;
  logic [BYTES-1:0]      b_keep;
  logic [KW-1:0]         keep_pop;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d   = state;
    start     = 1'b0;
    adv       = 1'b0;
    run_d     = run_q;
    seq_d     = seq_q;
    pkt_d     = pkt_count;
    bcnt_d    = byte_count;
    gap_cnt_d = gap_cnt_q;
    hs        = m00_axis_tvalid && m00_axis_tready;
    // a zero-length packet is never started, not even back-to-back
    can_start = enable && (packet_len != '0);
    keep_pop  = '0;
    for (int i = 0; i < BYTES; i++) keep_pop = keep_pop + KW'(m00_axis_tkeep[i]);

    case (state)
      IDLE: if (can_start) begin
        start   = 1'b1;
        run_d   = '0;
        state_d = SEND;
      end
      SEND: if (hs) begin
        bcnt_d = byte_count + (CNT_WIDTH+16)'(keep_pop);
        if (m00_axis_tlast) begin
          seq_d = seq_q + 16'd1;
          pkt_d = pkt_count + CNT_WIDTH'(1);
          run_d = run_q + CNT_WIDTH'(1);
          if (num_q != '0 && run_d == num_q) state_d = DONE;
          else if (gap_q != '0) begin
            state_d   = GAP;
            gap_cnt_d = gap_q;
          end
          else if (can_start) start = 1'b1;   // back-to-back, stay in SEND
          else state_d = IDLE;
        end else begin
          adv = 1'b1;
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q - LEN_WIDTH'(1);
        if (gap_cnt_q == LEN_WIDTH'(1)) begin
          if (can_start) begin
            start   = 1'b1;
            state_d = SEND;
          end else state_d = IDLE;
        end
      end
      DONE: if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Build the next beat: either the first beat of a freshly latched packet
    // or the beat following the one just accepted.
    b_mode = mode_q;
    b_pat  = pat_q;
    b_idx  = beat_idx_q + 16'd1;
    b_left = left_q - BYTES_L;
    b_lfsr = lfsr_q;
    if (start) begin
      b_mode = mode;
      b_pat  = pattern;
      b_idx  = '0;
      b_left = packet_len;
      b_lfsr = (pattern[30:0] == '0) ? 31'd1 : pattern[30:0];
    end
    // PRBS31 x^31+x^28+1: one feedback bit per output bit, LSB of tdata first
    s = b_lfsr;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      nb      = s[30] ^ s[27];
      prbs[i] = nb;
      s       = {s[29:0], nb};
    end
    for (int i = 0; i < BYTES; i++) b_keep[i] = (LEN_WIDTH'(i) < b_left);

    tdata_d    = m00_axis_tdata;
    tkeep_d    = m00_axis_tkeep;
    tlast_d    = m00_axis_tlast;
    lfsr_d     = lfsr_q;
    beat_idx_d = beat_idx_q;
    left_d     = left_q;
    if (start || adv) begin
      tdata_d    = b_mode ? prbs : {b_pat[DATA_WIDTH-1:32], seq_d, b_idx};
      tkeep_d    = b_keep;
      tlast_d    = (b_left <= BYTES_L);
      lfsr_d     = s;
      beat_idx_d = b_idx;
      left_d     = b_left;
    end else if (state_d != SEND) begin
      tdata_d = '0;
      tkeep_d = '0;
      tlast_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gap_q <= '0; mode_q <= 1'b0; pat_q <= '0; num_q <= '0; run_q <= '0;
      left_q <= '0; gap_cnt_q <= '0; beat_idx_q <= '0; seq_q <= '0; lfsr_q <= '0;
      m00_axis_tdata <= '0; m00_axis_tkeep <= '0; m00_axis_tlast <= 1'b0;
      m00_axis_tvalid <= 1'b0; busy <= 1'b0; done <= 1'b0;
      pkt_count <= '0; byte_count <= '0;
    end else begin
      if (start) begin
        gap_q  <= gap_cycles;
        mode_q <= mode;
        pat_q  <= pattern;
        num_q  <= num_packets;
      end
      run_q           <= run_d;
      left_q          <= left_d;
      gap_cnt_q       <= gap_cnt_d;
      beat_idx_q      <= beat_idx_d;
      seq_q           <= seq_d;
      lfsr_q          <= lfsr_d;
      m00_axis_tdata  <= tdata_d;
      m00_axis_tkeep  <= tkeep_d;
      m00_axis_tlast  <= tlast_d;
      m00_axis_tvalid <= (state_d == SEND);
      busy            <= (state_d != IDLE);
      done            <= (state_d == DONE);
      pkt_count       <= pkt_d;
      byte_count      <= bcnt_d;
    end
  end
endmodule

// File: tb/tb_eth_axis_packet_gen.sv
// Bench for eth_axis_packet_gen: a packet-level model builds the expected beat
// stream per packet; a negedge monitor compares every accepted beat against it
// and checks that data is held stable while stalled.
module tb_eth_axis_packet_gen;
  localparam int DW = 64, LW = 16, CW = 32, BY = DW / 8;

  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b0, mode = 1'b0, tready = 1'b1;
  logic [LW-1:0] packet_len = '0, gap_cycles = '0;
  logic [CW-1:0] num_packets = '0;
  logic [DW-1:0] pattern = '0;
  logic [DW-1:0] tdata;
  logic [BY-1:0] tkeep;
  logic tvalid, tlast, busy, done;
  logic [CW-1:0] pkt_count;
  logic [CW+15:0] byte_count;

  always #5 clk = ~clk;

  eth_axis_packet_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .packet_len(packet_len), .gap_cycles(gap_cycles), .num_packets(num_packets),
    .pattern(pattern), .m00_axis_tdata(tdata), .m00_axis_tkeep(tkeep),
    .m00_axis_tvalid(tvalid), .m00_axis_tready(tready), .m00_axis_tlast(tlast),
    .busy(busy), .done(done), .pkt_count(pkt_count), .byte_count(byte_count)
  );

  int checks = 0, errors = 0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- packet-level model ----------------
  typedef struct {
    logic [DW-1:0] data;
    logic [BY-1:0] keep;
    logic          last;
  } beat_t;
  beat_t expq[$];
  int unsigned m_seq = 0;
  longint unsigned m_pkts = 0, m_bytes = 0;

  task automatic push_pkt(int len, logic md, logic [DW-1:0] pat);
    int nb = (len + BY - 1) / BY;
    bit a[];
    logic [30:0] seed = pat[30:0];
    beat_t bt;
    if (seed == 0) seed = 31'd1;
    // PRBS31 bit sequence: a[n] = a[n-31] ^ a[n-28], seed occupies a[0..30]
    a = new[31 + nb * DW];
    for (int k = 0; k < 31; k++) a[k] = seed[30-k];
    for (int n = 31; n < 31 + nb * DW; n++) a[n] = a[n-31] ^ a[n-28];
    for (int b = 0; b < nb; b++) begin
      bt.last = (b == nb - 1);
      bt.keep = '1;
      if (bt.last && (len % BY) != 0) bt.keep = BY'((1 << (len % BY)) - 1);
      if (md) for (int i = 0; i < DW; i++) bt.data[i] = a[31 + b * DW + i];
      else    bt.data = {pat[DW-1:32], m_seq[15:0], b[15:0]};
      expq.push_back(bt);
    end
    m_seq++;
    m_pkts++;
    m_bytes += longint'(len);
  endtask

  // ---------------- tready driver ----------------
  bit rand_rdy = 1'b0;
  always @(posedge clk) begin
    #1;
    tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- monitor ----------------
  bit mon_en = 1'b0, prev_stall = 1'b0, counting = 1'b0;
  beat_t prev, e;
  int gap_run = 0, last_gap = -1;
  logic [DW-1:0] rx_data[$];
  logic [BY-1:0] rx_keep[$];

  always @(negedge clk) if (mon_en) begin
    if (prev_stall)
      chk("stall_hold", {tvalid, tlast, tkeep, tdata}, {1'b1, prev.last, prev.keep, prev.data});
    if (counting) begin
      if (!tvalid) gap_run++;
      else begin
        last_gap = gap_run;
        counting = 1'b0;
      end
    end
    if (tvalid && tready) begin
      rx_data.push_back(tdata);
      rx_keep.push_back(tkeep);
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data %0h, expected no beat", tdata);
      end else begin
        e = expq.pop_front();
        chk("beat", {tlast, tkeep, tdata}, {e.last, e.keep, e.data});
      end
      if (tlast) begin
        counting = 1'b1;
        gap_run  = 0;
      end
    end
    prev_stall = tvalid && !tready;
    prev.data  = tdata;
    prev.keep  = tkeep;
    prev.last  = tlast;
  end

  // ---------------- helpers ----------------
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    expq.delete();
    m_seq = 0; m_pkts = 0; m_bytes = 0;
    prev_stall = 1'b0; counting = 1'b0;
  endtask

  task automatic wait_done(string name, int budget);
    int c = 0;
    while (!done && c < budget) begin
      tick();
      c++;
    end
    chk(name, done, 1'b1);
  endtask

  task automatic wait_rx(string name, int n, int budget);
    int c = 0;
    while (rx_data.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk(name, rx_data.size() >= n, 1'b1);
  endtask

  task automatic run(int len, int gap, logic md, logic [DW-1:0] pat, int num);
    for (int p = 0; p < num; p++) push_pkt(len, md, pat);
    packet_len = LW'(len); gap_cycles = LW'(gap); mode = md;
    pattern = pat; num_packets = CW'(num); enable = 1'b1;
  endtask

  task automatic stop(string name);
    enable = 1'b0;
    tick(2);
    chk({name, "_idle"}, {done, busy}, 2'b00);
  endtask

  localparam logic [DW-1:0] PAT1 = 64'hA5A5_5A5A_0000_0000;
  localparam logic [DW-1:0] PRBS_SEED1_B0 = 64'h2080_0000_4800_0000;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    tick(3);
    reset = 1'b0;
    tick();
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_tlast", tlast, 1'b0);
    chk("rst_tkeep", tkeep, '0);
    chk("rst_tdata", tdata, '0);
    chk("rst_busy_done", {busy, done}, 2'b00);
    chk("rst_counts", {pkt_count, byte_count}, '0);
    model_reset();
    mon_en = 1'b1;

    // 1: 3 x 64-byte back-to-back packets
    rx_data.delete(); rx_keep.delete(); last_gap = -1;
    run(64, 0, 1'b0, PAT1, 3);
    wait_done("t1_done", 200);
    chk("t1_expq_empty", expq.size(), 0);
    chk("t1_beats", rx_data.size(), 24);
    chk("t1_contiguous", last_gap, 0);
    chk("t1_pkt_count", pkt_count, 3);
    chk("t1_byte_count", byte_count, 192);
    chk("t1_model_bytes", m_bytes, 192);
    chk("t1_beat0", rx_data[0], 64'hA5A5_5A5A_0000_0000);
    chk("t1_beat8", rx_data[8], 64'hA5A5_5A5A_0001_0000);
    chk("t1_beat23", rx_data[23], 64'hA5A5_5A5A_0002_0007);
    stop("t1");

    // 2: 61-byte packet, partial last keep; then zero length
    rx_data.delete(); rx_keep.delete();
    run(61, 0, 1'b0, PAT1, 1);
    wait_done("t2_done", 100);
    chk("t2_beats", rx_data.size(), 8);
    chk("t2_keep6", rx_keep[6], 8'hFF);
    chk("t2_keep7", rx_keep[7], 8'h1F);
    chk("t2_byte_count", byte_count, 253);
    stop("t2");
    begin
      bit seen = 1'b0;
      packet_len = '0;
      enable = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (tvalid || busy) seen = 1'b1;
      end
      chk("t2_len0_quiet", seen, 1'b0);
      enable = 1'b0;
      tick();
    end

    // 3: inter-packet gap of 5
    last_gap = -1;
    run(16, 5, 1'b0, PAT1, 2);
    wait_done("t3_done", 100);
    chk("t3_gap", last_gap, 5);
    stop("t3");

    // 4: 100 packets of 100 bytes with random backpressure
    rand_rdy = 1'b1;
    run(100, 0, 1'b0, 64'h1234_5678_0000_0000, 100);
    wait_done("t4_done", 20000);
    rand_rdy = 1'b0;
    tick();
    chk("t4_expq_empty", expq.size(), 0);
    chk("t4_pkt_count", pkt_count, CW'(m_pkts));
    chk("t4_byte_count", byte_count, (CW+16)'(m_bytes));
    stop("t4");

    // 5a: enable dropped mid-packet, packet still completes
    rx_data.delete(); rx_keep.delete();
    push_pkt(64, 1'b0, PAT1);
    packet_len = 64; gap_cycles = 0; mode = 1'b0; pattern = PAT1;
    num_packets = 0; enable = 1'b1;
    wait_rx("t5a_reach3", 3, 50);
    enable = 1'b0;
    tick(20);
    chk("t5a_beats", rx_data.size(), 8);
    chk("t5a_expq_empty", expq.size(), 0);
    chk("t5a_idle", {busy, tvalid}, 2'b00);
    chk("t5a_pkt_count", pkt_count, CW'(m_pkts));

    // 5b: reset mid-packet
    rx_data.delete(); rx_keep.delete();
    push_pkt(64, 1'b0, PAT1);
    enable = 1'b1;
    wait_rx("t5b_reach3", 3, 50);
    mon_en = 1'b0;
    reset = 1'b1;
    enable = 1'b0;
    tick();
    chk("t5b_tvalid_tlast", {tvalid, tlast}, 2'b00);
    chk("t5b_counts", {pkt_count, byte_count}, '0);
    chk("t5b_busy", busy, 1'b0);
    reset = 1'b0;
    model_reset();
    mon_en = 1'b1;
    tick();

    // 6: PRBS31 payload, seed 1 and seed 0 (treated as 1)
    rx_data.delete(); rx_keep.delete();
    run(20, 0, 1'b1, 64'h1, 1);
    wait_done("t6_done_s1", 100);
    stop("t6s1");
    chk("t6_seed1_beat0", rx_data[0], PRBS_SEED1_B0);
    chk("t6_seed1_keep2", rx_keep[2], 8'h0F);
    rx_data.delete(); rx_keep.delete();
    run(20, 0, 1'b1, 64'hFFFF_FFFF_8000_0000, 1);
    wait_done("t6_done_s0", 100);
    stop("t6s0");
    chk("t6_seed0_beat0", rx_data[0], PRBS_SEED1_B0);
    chk("t6_expq_empty", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
